// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared constants, types and helpers for the pipelined
//            carry-lookahead adder (cla_pipe_adder) and its 4-bit group.
// Contents : CLA_GROUP_W - width of one lookahead group
//            cla_ctl_t   - per-stage control payload (carry, valid)
//            cla_ovf()   - signed overflow from the two top carries
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

   localparam int CLA_GROUP_W = 4;

   // Control part of the stage payload. The datapath part (partial sum and
   // operand tails) depends on WIDTH, so it is wrapped around this struct
   // inside the adder itself.
   typedef struct packed {
      logic carry;   // carry into the next slice
      logic valid;   // slot holds a real operation
   } cla_ctl_t;

   // Two's-complement overflow: carry into the MSB differs from carry out.
   function automatic logic cla_ovf(input logic c_into_msb, input logic c_out_msb);
      return c_into_msb ^ c_out_msb;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
// ============================================================================
// Module   : cla_group4
// Purpose  : 4-bit carry-lookahead group. All internal carries are computed
//            directly from generate/propagate terms (no internal ripple) and
//            the group generate/propagate are exported for chaining.
// Ports    : a, b  [3:0] in  - operand bits
//            cin         in  - carry into bit 0
//            sum   [3:0] out - sum bits
//            g           out - group generate
//            p           out - group propagate
// Revision : 1.0 - initial release
// ============================================================================
module cla_group4
   import cla_pkg::*;
(
   input  logic [CLA_GROUP_W-1:0] a,
   input  logic [CLA_GROUP_W-1:0] b,
   input  logic                   cin,
   output logic [CLA_GROUP_W-1:0] sum,
   output logic                   g,
   output logic                   p
);

   logic [CLA_GROUP_W-1:0] w_g;
   logic [CLA_GROUP_W-1:0] w_p;
   logic [CLA_GROUP_W-1:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);

   assign sum = w_p ^ w_c;

   assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign p = &w_p;

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : Pipelined carry-lookahead adder/subtractor. A WIDTH-bit
//            operation is split into STAGES slices; each stage resolves one
//            slice with chained 4-bit lookahead groups and registers the
//            carry for the next. One operation per clock, latency STAGES.
//            A single global stall freezes the whole pipe when the output
//            slot is occupied and not being taken.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            InputA, InputB [W]   - operands
//            Cin                  - carry-in (add) / borrow-in (sub)
//            Sub                  - 0: A+B+Cin, 1: A-B-Cin
//            in_valid / in_ready  - input handshake
//            Out [W], Cout, Ovf   - result, raw MSB carry, signed overflow
//            out_valid / out_ready- output handshake
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] InputA,
   input  logic [WIDTH-1:0] InputB,
   input  logic             Cin,
   input  logic             Sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Out,
   output logic             Cout,
   output logic             Ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int c_stg    = (STAGES < 1) ? 1 : STAGES;
   localparam int c_slice  = WIDTH / c_stg;
   localparam int c_ngrp   = c_slice / CLA_GROUP_W;

   if ((STAGES < 1) || ((WIDTH % (CLA_GROUP_W * c_stg)) != 0)) begin : g_param_check
      $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES and STAGES >= 1");
   end

   // Stage payload. Operand tails shift right by one slice per stage so the
   // active slice is always at the bottom; the partial sum shifts right with
   // each new slice entering at the top, so after the last stage it is the
   // aligned result.
   typedef struct packed {
      logic [WIDTH-1:0] psum;
      logic [WIDTH-1:0] atail;
      logic [WIDTH-1:0] btail;
      cla_ctl_t         ctl;
   } stage_t;

   stage_t             r_pipe [c_stg];
   stage_t             w_in   [c_stg];
   stage_t             w_next [c_stg];
   logic [c_slice-1:0] w_sum  [c_stg];
   logic [c_ngrp:0]    w_gc   [c_stg];
   logic [c_ngrp-1:0]  w_gg   [c_stg];
   logic [c_ngrp-1:0]  w_gp   [c_stg];

   logic             w_en;
   logic [WIDTH-1:0] w_bop;
   logic             w_c0;
   logic             w_c_msb;
   logic             r_ovf;

   // Subtraction as A + ~B + ~Cin: borrow-in becomes an inverted carry-in.
   assign w_bop = Sub ? ~InputB : InputB;
   assign w_c0  = Sub ? ~Cin    : Cin;

   // Global stall: everything advances only if the output slot frees up.
   assign w_en     = !r_pipe[c_stg-1].ctl.valid || out_ready;
   assign in_ready = w_en;

   for (genvar k = 0; k < c_stg; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign w_in[k] = '{psum:  '0,
                            atail: InputA,
                            btail: w_bop,
                            ctl:   '{carry: w_c0, valid: in_valid}};
      end else begin : g_body
         assign w_in[k] = r_pipe[k-1];
      end

      assign w_gc[k][0] = w_in[k].ctl.carry;

      for (genvar j = 0; j < c_ngrp; j++) begin : g_grp
         cla_group4 u_grp (
            .a   (w_in[k].atail[j*CLA_GROUP_W +: CLA_GROUP_W]),
            .b   (w_in[k].btail[j*CLA_GROUP_W +: CLA_GROUP_W]),
            .cin (w_gc[k][j]),
            .sum (w_sum[k][j*CLA_GROUP_W +: CLA_GROUP_W]),
            .g   (w_gg[k][j]),
            .p   (w_gp[k][j])
         );
         assign w_gc[k][j+1] = w_gg[k][j] | (w_gp[k][j] & w_gc[k][j]);
      end

      assign w_next[k] = '{psum:  (w_in[k].psum >> c_slice) |
                                  (WIDTH'(w_sum[k]) << (WIDTH - c_slice)),
                           atail: w_in[k].atail >> c_slice,
                           btail: w_in[k].btail >> c_slice,
                           ctl:   '{carry: w_gc[k][c_ngrp], valid: w_in[k].ctl.valid}};
   end

   // Carry into the MSB recovered from the top sum bit: s = a ^ b ^ c.
   assign w_c_msb = w_sum[c_stg-1][c_slice-1]
                  ^ w_in[c_stg-1].atail[c_slice-1]
                  ^ w_in[c_stg-1].btail[c_slice-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_stg; i++) begin
            r_pipe[i] <= '0;
         end
         r_ovf <= 1'b0;
      end else if (w_en) begin
         for (int i = 0; i < c_stg; i++) begin
            r_pipe[i] <= w_next[i];
         end
         r_ovf <= cla_ovf(w_c_msb, w_gc[c_stg-1][c_ngrp]);
      end
   end

   assign Out       = r_pipe[c_stg-1].psum;
   assign Cout      = r_pipe[c_stg-1].ctl.carry;
   assign out_valid = r_pipe[c_stg-1].ctl.valid;
   assign Ovf       = r_ovf;

endmodule
`default_nettype wire
